// File: rtl/video_pll_pkg.sv
// Video rPLL mode table, divider-code encoders and sequencer state type.
package video_pll_pkg;

  typedef logic [1:0] mode_t;

  typedef enum logic [1:0] {
    ST_APPLY     = 2'd0,
    ST_WAIT_LOCK = 2'd1,
    ST_RUN       = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0] idiv_sel;
    logic [5:0] fbdiv_sel;
    logic [5:0] odiv_code;
  } mode_cfg_t;

  localparam mode_cfg_t MODE0_CFG = '{idiv_sel: 6'd3,  fbdiv_sel: 6'd14, odiv_code: 6'd8};
  localparam mode_cfg_t MODE1_CFG = '{idiv_sel: 6'd19, fbdiv_sel: 6'd20, odiv_code: 6'd32};
  localparam mode_cfg_t MODE2_CFG = '{idiv_sel: 6'd2,  fbdiv_sel: 6'd4,  odiv_code: 6'd16};
  localparam mode_cfg_t MODE3_CFG = '{idiv_sel: 6'd9,  fbdiv_sel: 6'd26, odiv_code: 6'd8};

  function automatic mode_cfg_t mode_cfg(input mode_t m);
    case (m)
      2'd0:    mode_cfg = MODE0_CFG;
      2'd1:    mode_cfg = MODE1_CFG;
      2'd2:    mode_cfg = MODE2_CFG;
      default: mode_cfg = MODE3_CFG;
    endcase
  endfunction

  // The rPLL dynamic select ports take the inverted divider setting.
  function automatic logic [5:0] enc_idsel(input mode_t m);
    mode_cfg_t c;
    c = mode_cfg(m);
    enc_idsel = ~c.idiv_sel;
  endfunction

  function automatic logic [5:0] enc_fbdsel(input mode_t m);
    mode_cfg_t c;
    c = mode_cfg(m);
    enc_fbdsel = ~c.fbdiv_sel;
  endfunction

  function automatic logic [5:0] enc_odsel(input mode_t m);
    mode_cfg_t c;
    c = mode_cfg(m);
    enc_odsel = c.odiv_code;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous level.
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_mode_sequencer.sv
// Video rPLL sequencer: applies divider codes, waits for stable lock, gates pixel reset.
//   state        | meaning
//   ST_APPLY     | pll_reset held high, codes of current_mode on the select ports
//   ST_WAIT_LOCK | PLL released, waiting for a stable synced lock or timeout
//   ST_RUN       | locked, pixel pipeline out of reset, accepting mode requests
module pll_mode_sequencer
  import video_pll_pkg::*;
#(
  parameter mode_t       DEFAULT_MODE        = 2'd0,
  parameter int unsigned RESET_HOLD_CYCLES   = 16,
  parameter int unsigned LOCK_STABLE_CYCLES  = 1024,
  parameter int unsigned LOCK_TIMEOUT_CYCLES = 48000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] mode_sel,
  input  logic       mode_req,
  output logic       mode_ack,
  output logic       busy,
  output logic [1:0] current_mode,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic [5:0] pll_idsel,
  output logic [5:0] pll_fbdsel,
  output logic [5:0] pll_odsel,
  output logic       video_rst_n,
  output logic       lock_err
);

  localparam int HOLD_W   = $clog2(RESET_HOLD_CYCLES + 1);
  localparam int STABLE_W = $clog2(LOCK_STABLE_CYCLES + 1);
  localparam int TMO_W    = $clog2(LOCK_TIMEOUT_CYCLES + 1);

  localparam logic [HOLD_W-1:0]   HOLD_LOAD   = HOLD_W'(RESET_HOLD_CYCLES - 1);
  localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [TMO_W-1:0]    TMO_LOAD    = TMO_W'(LOCK_TIMEOUT_CYCLES - 1);

  logic lock_s;

  sync_2ff u_lock_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (pll_lock),
    .q     (lock_s)
  );

  state_t              state, state_nxt;
  logic [HOLD_W-1:0]   hold_cnt, hold_nxt;
  logic [STABLE_W-1:0] stable_cnt, stable_nxt;
  logic [TMO_W-1:0]    tmo_cnt, tmo_nxt;
  logic                lock_low, lock_low_nxt;
  logic                ack_pend, ack_pend_nxt;
  mode_t               mode_nxt;
  logic                load_codes;
  logic                pll_reset_nxt, video_rst_n_nxt, busy_nxt, ack_nxt, lock_err_nxt;
  logic [5:0]          idsel_nxt, fbdsel_nxt, odsel_nxt;

  always_comb begin
    state_nxt       = state;
    hold_nxt        = hold_cnt;
    stable_nxt      = stable_cnt;
    tmo_nxt         = tmo_cnt;
    lock_low_nxt    = 1'b0;
    ack_pend_nxt    = ack_pend;
    mode_nxt        = current_mode;
    load_codes      = 1'b0;
    pll_reset_nxt   = pll_reset;
    video_rst_n_nxt = video_rst_n;
    busy_nxt        = busy;
    ack_nxt         = 1'b0;
    lock_err_nxt    = lock_err;

    case (state)
      ST_APPLY: begin
        if (hold_cnt == '0) begin
          state_nxt     = ST_WAIT_LOCK;
          pll_reset_nxt = 1'b0;
          stable_nxt    = '0;
          tmo_nxt       = TMO_LOAD;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end

      ST_WAIT_LOCK: begin
        stable_nxt = lock_s ? stable_cnt + 1'b1 : '0;
        tmo_nxt    = tmo_cnt - 1'b1;
        // Reaching the stable threshold takes priority over an expiring timeout.
        if (lock_s && stable_cnt == STABLE_LAST) begin
          state_nxt       = ST_RUN;
          video_rst_n_nxt = 1'b1;
          busy_nxt        = 1'b0;
          lock_err_nxt    = 1'b0;
          ack_nxt         = ack_pend;
          ack_pend_nxt    = 1'b0;
        end else if (tmo_cnt == '0) begin
          state_nxt     = ST_APPLY;
          lock_err_nxt  = 1'b1;
          pll_reset_nxt = 1'b1;
          hold_nxt      = HOLD_LOAD;
          load_codes    = 1'b1;
        end
      end

      ST_RUN: begin
        lock_low_nxt = ~lock_s;
        if (!lock_s && lock_low) begin
          state_nxt       = ST_WAIT_LOCK;
          video_rst_n_nxt = 1'b0;
          busy_nxt        = 1'b1;
          stable_nxt      = '0;
          tmo_nxt         = TMO_LOAD;
        end else if (mode_req) begin
          if (mode_sel != current_mode) begin
            state_nxt       = ST_APPLY;
            mode_nxt        = mode_sel;
            load_codes      = 1'b1;
            video_rst_n_nxt = 1'b0;
            busy_nxt        = 1'b1;
            pll_reset_nxt   = 1'b1;
            hold_nxt        = HOLD_LOAD;
            ack_pend_nxt    = 1'b1;
          end else begin
            ack_nxt = 1'b1;
          end
        end
      end

      default: begin
        state_nxt     = ST_APPLY;
        pll_reset_nxt = 1'b1;
        hold_nxt      = HOLD_LOAD;
        load_codes    = 1'b1;
      end
    endcase

    idsel_nxt  = load_codes ? enc_idsel(mode_nxt)  : pll_idsel;
    fbdsel_nxt = load_codes ? enc_fbdsel(mode_nxt) : pll_fbdsel;
    odsel_nxt  = load_codes ? enc_odsel(mode_nxt)  : pll_odsel;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= ST_APPLY;
      hold_cnt     <= HOLD_LOAD;
      stable_cnt   <= '0;
      tmo_cnt      <= TMO_LOAD;
      lock_low     <= 1'b0;
      ack_pend     <= 1'b0;
      current_mode <= DEFAULT_MODE;
      pll_reset    <= 1'b1;
      video_rst_n  <= 1'b0;
      busy         <= 1'b1;
      mode_ack     <= 1'b0;
      lock_err     <= 1'b0;
      pll_idsel    <= enc_idsel(DEFAULT_MODE);
      pll_fbdsel   <= enc_fbdsel(DEFAULT_MODE);
      pll_odsel    <= enc_odsel(DEFAULT_MODE);
    end else begin
      state        <= state_nxt;
      hold_cnt     <= hold_nxt;
      stable_cnt   <= stable_nxt;
      tmo_cnt      <= tmo_nxt;
      lock_low     <= lock_low_nxt;
      ack_pend     <= ack_pend_nxt;
      current_mode <= mode_nxt;
      pll_reset    <= pll_reset_nxt;
      video_rst_n  <= video_rst_n_nxt;
      busy         <= busy_nxt;
      mode_ack     <= ack_nxt;
      lock_err     <= lock_err_nxt;
      pll_idsel    <= idsel_nxt;
      pll_fbdsel   <= fbdsel_nxt;
      pll_odsel    <= odsel_nxt;
    end
  end

endmodule

// File: tb/tb_pll_mode_sequencer.sv
// Bench for pll_mode_sequencer: directed sequences plus a mode_ack scoreboard.
module tb_pll_mode_sequencer;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [1:0] mode_sel;
  logic       mode_req;
  logic       mode_ack;
  logic       busy;
  logic [1:0] current_mode;
  logic       pll_lock;
  logic       pll_reset;
  logic [5:0] pll_idsel;
  logic [5:0] pll_fbdsel;
  logic [5:0] pll_odsel;
  logic       video_rst_n;
  logic       lock_err;

  typedef struct packed {
    logic [1:0] mode;
    logic [5:0] idsel;
    logic [5:0] fbdsel;
    logic [5:0] odsel;
  } exp_t;

  exp_t sb_q[$];
  exp_t sb_e;
  int   n_vec = 0;
  int   n_err = 0;
  int   n;
  bit   rst_seen;

  always #10 clk = ~clk;

  pll_mode_sequencer dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .mode_sel     (mode_sel),
    .mode_req     (mode_req),
    .mode_ack     (mode_ack),
    .busy         (busy),
    .current_mode (current_mode),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .pll_idsel    (pll_idsel),
    .pll_fbdsel   (pll_fbdsel),
    .pll_odsel    (pll_odsel),
    .video_rst_n  (video_rst_n),
    .lock_err     (lock_err)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Hand-encoded select codes: idsel/fbdsel are the inverted divider settings.
  function automatic exp_t exp_codes(input logic [1:0] m);
    case (m)
      2'd0:    exp_codes = '{mode: 2'd0, idsel: 6'h3C, fbdsel: 6'h31, odsel: 6'd8};
      2'd1:    exp_codes = '{mode: 2'd1, idsel: 6'h2C, fbdsel: 6'h2B, odsel: 6'd32};
      2'd2:    exp_codes = '{mode: 2'd2, idsel: 6'h3D, fbdsel: 6'h3B, odsel: 6'd16};
      default: exp_codes = '{mode: 2'd3, idsel: 6'h36, fbdsel: 6'h25, odsel: 6'd8};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    if (pll_reset === 1'b1) rst_seen = 1'b1;
  endtask

  task automatic wait_video(input logic v, input int max, output int cnt);
    cnt = 0;
    while (video_rst_n !== v && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_pll_reset(input logic v, input int max, output int cnt);
    cnt = 0;
    while (pll_reset !== v && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic wait_lock_err(input logic v, input int max, output int cnt);
    cnt = 0;
    while (lock_err !== v && cnt < max) begin
      tick();
      cnt++;
    end
  endtask

  task automatic chk_reset_state(input string tag);
    exp_t d;
    d = exp_codes(2'd0);
    chk({tag, "_pll_reset"}, pll_reset, 1'b1);
    chk({tag, "_video_rst_n"}, video_rst_n, 1'b0);
    chk({tag, "_busy"}, busy, 1'b1);
    chk({tag, "_mode_ack"}, mode_ack, 1'b0);
    chk({tag, "_lock_err"}, lock_err, 1'b0);
    chk({tag, "_current_mode"}, current_mode, d.mode);
    chk({tag, "_idsel"}, pll_idsel, d.idsel);
    chk({tag, "_fbdsel"}, pll_fbdsel, d.fbdsel);
    chk({tag, "_odsel"}, pll_odsel, d.odsel);
  endtask

  // Every mode_ack must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && mode_ack === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("ack_unexpected", mode_ack, 1'b0);
      end else begin
        sb_e = sb_q.pop_front();
        chk("ack_mode", current_mode, sb_e.mode);
        chk("ack_idsel", pll_idsel, sb_e.idsel);
        chk("ack_fbdsel", pll_fbdsel, sb_e.fbdsel);
        chk("ack_odsel", pll_odsel, sb_e.odsel);
        chk("ack_busy", busy, 1'b0);
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    pll_lock = 1'b0;
    mode_sel = 2'd0;
    mode_req = 1'b0;
    rst_seen = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    chk_reset_state("por");

    // Power-up: reset held 16 cycles, lock arrives at cycle 20.
    rst_n = 1'b1;
    wait_pll_reset(1'b0, 40, n);
    chk("pwr_reset_hold", n, 16);
    repeat (4) tick();
    pll_lock = 1'b1;
    wait_video(1'b1, 2000, n);
    chk("pwr_lock_latency", n, 1026);
    chk("pwr_busy", busy, 1'b0);
    chk("pwr_idsel", pll_idsel, 6'h3C);
    chk("pwr_fbdsel", pll_fbdsel, 6'h31);
    chk("pwr_pll_reset", pll_reset, 1'b0);

    // Mode change to 2; PLL loses lock while reset and for 100 cycles after.
    mode_sel = 2'd2;
    mode_req = 1'b1;
    pll_lock = 1'b0;
    sb_q.push_back(exp_codes(2'd2));
    tick();
    mode_req = 1'b0;
    chk("chg_video_rst_n", video_rst_n, 1'b0);
    chk("chg_pll_reset", pll_reset, 1'b1);
    chk("chg_busy", busy, 1'b1);
    chk("chg_current_mode", current_mode, 2'd2);
    chk("chg_idsel", pll_idsel, 6'h3D);
    chk("chg_fbdsel", pll_fbdsel, 6'h3B);
    chk("chg_odsel", pll_odsel, 6'd16);
    mode_sel = 2'd3;
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_pll_reset(1'b0, 40, n);
    chk("chg_reset_hold", n + 1, 16);
    repeat (100) tick();
    pll_lock = 1'b1;
    rst_seen = 1'b0;
    wait_video(1'b1, 1200, n);
    chk("chg_lock_latency", n, 1026);
    chk("chg_busy_ignored", current_mode, 2'd2);
    chk("chg_no_reset_pulse", rst_seen, 1'b0);
    tick();
    chk("chg_ack_single", mode_ack, 1'b0);
    chk("chg_sb_drained", sb_q.size(), 0);

    // Same-mode request: ack one cycle later, nothing else moves.
    mode_sel = 2'd2;
    mode_req = 1'b1;
    sb_q.push_back(exp_codes(2'd2));
    tick();
    mode_req = 1'b0;
    chk("same_ack", mode_ack, 1'b1);
    chk("same_pll_reset", pll_reset, 1'b0);
    chk("same_video_rst_n", video_rst_n, 1'b1);
    chk("same_busy", busy, 1'b0);
    tick();
    chk("same_ack_single", mode_ack, 1'b0);
    chk("same_sb_drained", sb_q.size(), 0);

    // Single-cycle lock glitch is filtered.
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    repeat (6) tick();
    chk("glitch1_video_rst_n", video_rst_n, 1'b1);
    chk("glitch1_busy", busy, 1'b0);

    // Two-cycle loss: drop to WAIT_LOCK without a PLL reset pulse, no ack on recovery.
    rst_seen = 1'b0;
    pll_lock = 1'b0;
    tick();
    tick();
    pll_lock = 1'b1;
    wait_video(1'b0, 10, n);
    chk("glitch2_fall_latency", n, 2);
    chk("glitch2_busy", busy, 1'b1);
    wait_video(1'b1, 1200, n);
    chk("glitch2_relock", n, 1024);
    chk("glitch2_no_reset_pulse", rst_seen, 1'b0);
    chk("glitch2_current_mode", current_mode, 2'd2);

    // Lock timeout: error after 48000 WAIT_LOCK cycles, same codes re-applied.
    pll_lock = 1'b0;
    wait_video(1'b0, 10, n);
    chk("tmo_enter_wait", video_rst_n, 1'b0);
    wait_lock_err(1'b1, 50000, n);
    chk("tmo_cycles", n, 48000);
    chk("tmo_pll_reset", pll_reset, 1'b1);
    chk("tmo_idsel", pll_idsel, 6'h3D);
    wait_pll_reset(1'b0, 40, n);
    chk("tmo_reapply_hold", n, 16);
    chk("tmo_lock_err_sticky", lock_err, 1'b1);
    pll_lock = 1'b1;
    wait_video(1'b1, 1200, n);
    chk("tmo_relock", n, 1026);
    chk("tmo_lock_err_clear", lock_err, 1'b0);

    // Reset asserted in WAIT_LOCK with mode 3 pending.
    mode_sel = 2'd3;
    mode_req = 1'b1;
    pll_lock = 1'b0;
    tick();
    mode_req = 1'b0;
    chk("mid_idsel_m3", pll_idsel, 6'h36);
    chk("mid_fbdsel_m3", pll_fbdsel, 6'h25);
    wait_pll_reset(1'b0, 40, n);
    repeat (10) tick();
    rst_n = 1'b0;
    #1;
    chk_reset_state("mid");
    repeat (3) tick();
    rst_n = 1'b1;
    mode_sel = 2'd3;
    mode_req = 1'b1;
    tick();
    mode_req = 1'b0;
    wait_pll_reset(1'b0, 40, n);
    chk("mid_reset_hold", n + 1, 16);
    pll_lock = 1'b1;
    wait_video(1'b1, 1200, n);
    chk("mid_relock", n, 1026);
    chk("mid_current_mode", current_mode, 2'd0);
    chk("mid_idsel", pll_idsel, 6'h3C);
    tick();
    chk("final_sb_drained", sb_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
